// File: rtl/multiplicador_algoritmico_pkg.sv
// Shared definitions for the sequential shift-add arithmetic blocks (multiplier, divider).
package multiplicador_algoritmico_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int TAMANYO_DEF = 32;

endpackage

// File: rtl/multiplicador_algoritmico.sv
// Sequential shift-add multiplier, one ADD/SHIFT pair per operand bit.
// MULT_SIGNED_EN defined: two's-complement operands (sign-magnitude core); undefined: unsigned.
//
// state | meaning
// IDLE  | waiting for Start, Done cleared
// ADD   | conditionally add M into ACCU when Q[0]=1
// SHIFT | shift {ACCU,Q} right, count down
// FIN   | load Prod (sign-corrected), pulse Done
module multiplicador_algoritmico
  import multiplicador_algoritmico_pkg::*;
#(
  parameter int tamanyo = TAMANYO_DEF
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   Start,
  input  logic [tamanyo-1:0]     A,
  input  logic [tamanyo-1:0]     B,
  output logic [2*tamanyo-1:0]   Prod,
  output logic                   Done
);

  localparam int CW = $clog2(tamanyo);

  state_t             state;
  logic [tamanyo:0]   accu;
  logic [tamanyo-1:0] m;
  logic [tamanyo-1:0] q;
  logic [CW-1:0]      cont;
`ifdef MULT_SIGNED_EN
  logic               sign_a;
  logic               sign_b;
`endif

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state  <= IDLE;
      Prod   <= '0;
      Done   <= 1'b0;
      accu   <= '0;
      m      <= '0;
      q      <= '0;
      cont   <= '0;
`ifdef MULT_SIGNED_EN
      sign_a <= 1'b0;
      sign_b <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
`ifdef MULT_SIGNED_EN
            // negating the most negative value wraps to 2^(tamanyo-1), the correct magnitude
            sign_a <= A[tamanyo-1];
            sign_b <= B[tamanyo-1];
            m      <= A[tamanyo-1] ? -A : A;
            q      <= B[tamanyo-1] ? -B : B;
`else
            m      <= A;
            q      <= B;
`endif
            accu   <= '0;
            cont   <= CW'(tamanyo - 1);
            state  <= ADD;
          end
        end
        ADD: begin
          if (q[0]) accu <= accu + {1'b0, m};
          state <= SHIFT;
        end
        SHIFT: begin
          {accu, q} <= {1'b0, accu, q[tamanyo-1:1]};
          cont      <= cont - 1'b1;
          state     <= (cont == '0) ? FIN : ADD;
        end
        FIN: begin
`ifdef MULT_SIGNED_EN
          Prod <= (sign_a ^ sign_b) ? -{accu[tamanyo-1:0], q} : {accu[tamanyo-1:0], q};
`else
          Prod <= {accu[tamanyo-1:0], q};
`endif
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
